// File: rtl/med_log_reader.sv
// med_log_reader: medication event log FIFO, drained oldest-first as UART
// frames (8N1, LSB first) on tx when a dump is requested.
// Ports: clk, rst_n (async, active-low); log_valid/log_data/log_ready write
//   side; dump_req starts a dump; tx serial out (idle high); busy during a
//   dump; entry_count stored entries; overflow sticky drop flag.
// Build option: define MED_LOG_PARITY_EN to add an even parity bit per frame.
module med_log_reader #(
    parameter int DEPTH        = 16,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     log_valid,
    input  logic [DATA_W-1:0]        log_data,
    output logic                     log_ready,
    input  logic                     dump_req,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   entry_count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] BIT_END  = NW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef MED_LOG_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [DATA_W-1:0]   shift;
    logic [BW-1:0]       baud;
    logic [NW-1:0]       bit_n;
    logic [CW-1:0]       dump_len;
`ifdef MED_LOG_PARITY_EN
    logic                par;
`endif

    logic wr_en;
    logic drop;
    logic pop;
    logic accept;

    assign log_ready = (entry_count != FULL);
    assign wr_en     = log_valid && log_ready;
    assign drop      = log_valid && !log_ready;
    assign pop       = (state == LOAD);
    assign accept    = (state == IDLE) && dump_req
                       && (entry_count != '0);

    // Storage carries no reset; emptiness is tracked by the count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= log_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            entry_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   entry_count <= entry_count + CW'(1);
                2'b01:   entry_count <= entry_count - CW'(1);
                default: entry_count <= entry_count;
            endcase
        end
    end

    // A drop in the same cycle as an accepted dump keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (accept) begin
            overflow <= 1'b0;
        end
    end

    // dump_len is latched at accept so later writes wait for the next dump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx       <= 1'b1;
            shift    <= '0;
            baud     <= '0;
            bit_n    <= '0;
            dump_len <= '0;
`ifdef MED_LOG_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        busy     <= 1'b1;
                        dump_len <= entry_count;
                        baud     <= '0;
                        bit_n    <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    shift    <= mem[rd_ptr];
`ifdef MED_LOG_PARITY_EN
                    par      <= ^mem[rd_ptr];
`endif
                    dump_len <= dump_len - CW'(1);
                    tx       <= 1'b0;
                    baud     <= '0;
                    bit_n    <= '0;
                    state    <= START;
                end
                START: begin
                    if (baud == BAUD_END) begin
                        baud  <= '0;
                        bit_n <= '0;
                        tx    <= shift[0];
                        state <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud == BAUD_END) begin
                        baud <= '0;
                        if (bit_n == BIT_END) begin
                            bit_n <= '0;
`ifdef MED_LOG_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shift <= shift >> 1;
                            tx    <= shift[1];
                            bit_n <= bit_n + NW'(1);
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`ifdef MED_LOG_PARITY_EN
                PARITY: begin
                    if (baud == BAUD_END) begin
                        baud  <= '0;
                        bit_n <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud == BAUD_END) begin
                        baud  <= '0;
                        bit_n <= '0;
                        if (dump_len != '0) begin
                            state <= LOAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
